// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pkg
//  Description : Shared constants and types for the RS(32,28) GF(256) codec.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

  // Field polynomial x^8 + x^4 + x^3 + x^2 + 1
  localparam logic [8:0] RS_FIELD_POLY = 9'h11D;

  // Number of parity symbols appended per codeword
  localparam int RS_N_PARITY = 4;

  // g(x) = x^4 + G3*x^3 + G2*x^2 + G1*x + G0, roots 1, a, a^2, a^3
  localparam logic [7:0] RS_G0 = 8'h40;
  localparam logic [7:0] RS_G1 = 8'h78;
  localparam logic [7:0] RS_G2 = 8'h36;
  localparam logic [7:0] RS_G3 = 8'h0F;

  typedef enum logic [0:0] {
    S_DATA   = 1'b0,
    S_PARITY = 1'b1
  } rs_state_e;

endpackage
`default_nettype wire

// File: rtl/gf256_mult.sv
`default_nettype none
// ============================================================================
//  Module      : gf256_mult
//  Description : Combinational GF(256) multiplier, reduction by RS_FIELD_POLY.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf256_mult
  import rs_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] acc;
  logic [7:0] sh;

  // Shift-and-add: walk the bits of b, doubling a (mod poly) each step
  always_comb begin
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ RS_FIELD_POLY[7:0]) : {sh[6:0], 1'b0};
    end
    p = acc;
  end

endmodule
`default_nettype wire

// File: rtl/rs_enc_parity_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rs_enc_parity_gen
//  Description : Systematic RS(32,28) encoder. Passes DATA_LEN data symbols
//                through and appends 4 parity symbols (p3 first).
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_enc_parity_gen
  import rs_pkg::*;
#(
  parameter int DATA_LEN = 28
) (
  input  logic       i_clk,
  input  logic       i_resb,
  input  logic       i_frame_sync,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_sof,
  output logic       o_eof
);

  localparam logic [7:0] LAST_DATA = 8'(DATA_LEN - 1);
  localparam logic [7:0] LAST_PAR  = 8'(RS_N_PARITY - 1);

  rs_state_e  state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] p0, p1, p2, p3;
  logic [7:0] p0_nxt, p1_nxt, p2_nxt, p3_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt, sof_nxt, eof_nxt;

  logic       slot_free;
  logic       accept;
  logic [7:0] fb;
  logic [7:0] m0, m1, m2, m3;

  // Single output register, no skid: a new symbol may load only when the
  // current one is absent or being taken this cycle.
  assign slot_free = !o_valid || i_ready;
  assign o_ready   = i_resb && !i_frame_sync && (state == S_DATA) && slot_free;
  assign accept    = i_valid && o_ready;
  assign fb        = i_data ^ p3;

  gf256_mult u_mul_g0 (.a(fb), .b(RS_G0), .p(m0));
  gf256_mult u_mul_g1 (.a(fb), .b(RS_G1), .p(m1));
  gf256_mult u_mul_g2 (.a(fb), .b(RS_G2), .p(m2));
  gf256_mult u_mul_g3 (.a(fb), .b(RS_G3), .p(m3));

  // Next-state: LFSR update on data accept, LFSR drain during parity
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    p0_nxt    = p0;
    p1_nxt    = p1;
    p2_nxt    = p2;
    p3_nxt    = p3;
    data_nxt  = o_data;
    valid_nxt = o_valid;
    sof_nxt   = o_sof;
    eof_nxt   = o_eof;

    if (slot_free) begin
      valid_nxt = 1'b0;
      sof_nxt   = 1'b0;
      eof_nxt   = 1'b0;
    end

    case (state)
      S_DATA: begin
        if (accept) begin
          p3_nxt    = p2 ^ m3;
          p2_nxt    = p1 ^ m2;
          p1_nxt    = p0 ^ m1;
          p0_nxt    = m0;
          data_nxt  = i_data;
          valid_nxt = 1'b1;
          sof_nxt   = (cnt == 8'd0);
          eof_nxt   = 1'b0;
          if (cnt == LAST_DATA) begin
            state_nxt = S_PARITY;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      S_PARITY: begin
        if (slot_free) begin
          data_nxt  = p3;
          p3_nxt    = p2;
          p2_nxt    = p1;
          p1_nxt    = p0;
          p0_nxt    = 8'h00;
          valid_nxt = 1'b1;
          sof_nxt   = 1'b0;
          eof_nxt   = (cnt == LAST_PAR);
          if (cnt == LAST_PAR) begin
            state_nxt = S_DATA;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nxt = S_DATA;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // State register; frame sync restarts exactly like reset
  always_ff @(posedge i_clk) begin
    if (!i_resb || i_frame_sync) begin
      state   <= S_DATA;
      cnt     <= 8'd0;
      p0      <= 8'h00;
      p1      <= 8'h00;
      p2      <= 8'h00;
      p3      <= 8'h00;
      o_data  <= 8'h00;
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      p0      <= p0_nxt;
      p1      <= p1_nxt;
      p2      <= p2_nxt;
      p3      <= p3_nxt;
      o_data  <= data_nxt;
      o_valid <= valid_nxt;
      o_sof   <= sof_nxt;
      o_eof   <= eof_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_enc_parity_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_enc_parity_gen
//  Description : Directed self-checking bench for rs_enc_parity_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_enc_parity_gen;

  localparam int DLEN = 28;
  localparam int NSYM = 32;

  logic       i_clk;
  logic       i_resb;
  logic       i_frame_sync;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_sof;
  logic       o_eof;

  rs_enc_parity_gen #(.DATA_LEN(DLEN)) dut (
    .i_clk        (i_clk),
    .i_resb       (i_resb),
    .i_frame_sync (i_frame_sync),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_sof        (o_sof),
    .o_eof        (o_eof)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pay [DLEN];
  logic [7:0] rec_data [NSYM];
  logic       rec_sof  [NSYM];
  logic       rec_eof  [NSYM];
  logic [7:0] ref_data [NSYM];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return r;
  endfunction

  // Evaluate the received codeword at root r (first symbol = highest degree)
  function automatic logic [7:0] syndrome(input logic [7:0] r);
    logic [7:0] acc = 8'h00;
    for (int k = 0; k < NSYM; k++) acc = gf_mul(acc, r) ^ rec_data[k];
    return acc;
  endfunction

  // Feed pay[] and collect 32 transferred output symbols; starts/ends at posedge+1
  task automatic run_frame(input bit stall, output int ready_low);
    int   in_idx  = 0;
    int   out_cnt = 0;
    int   cycles  = 0;
    logic hold    = 1'b0;
    logic [7:0] hd = 8'h00;
    logic hs = 1'b0, he = 1'b0;
    ready_low = 0;
    while (out_cnt < NSYM && cycles < 2000) begin
      i_valid = (in_idx < DLEN) && (!stall || ($urandom_range(0, 3) != 0));
      i_data  = (in_idx < DLEN) ? pay[in_idx] : 8'h00;
      i_ready = !stall || ($urandom_range(0, 2) != 0);
      @(negedge i_clk);
      if (hold) begin
        check_eq("hold_data", {24'h0, o_data}, {24'h0, hd});
        check_eq("hold_flags", {30'h0, o_valid, o_sof ^ hs, o_eof ^ he}, 32'h4);
      end
      if (!o_ready) ready_low++;
      if (i_valid && o_ready) in_idx++;
      if (o_valid && i_ready) begin
        rec_data[out_cnt] = o_data;
        rec_sof[out_cnt]  = o_sof;
        rec_eof[out_cnt]  = o_eof;
        out_cnt++;
      end
      hold = o_valid && !i_ready;
      hd = o_data; hs = o_sof; he = o_eof;
      @(posedge i_clk); #1;
      cycles++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    if (out_cnt < NSYM) check_eq("frame_timeout", out_cnt, NSYM);
  endtask

  // Stall-free drive of pay[] for n cycles; starts/ends at posedge+1
  task automatic drive_n(input int n);
    int idx = 0;
    for (int c = 0; c < n; c++) begin
      i_valid = (idx < DLEN);
      i_data  = (idx < DLEN) ? pay[idx] : 8'h00;
      i_ready = 1'b1;
      @(negedge i_clk);
      if (i_valid && o_ready) idx++;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [31:0] par);
    int ns = 0, ne = 0;
    for (int k = 0; k < DLEN; k++)
      check_eq({tag, "_data"}, {24'h0, rec_data[k]}, {24'h0, pay[k]});
    for (int k = 0; k < 4; k++)
      check_eq({tag, "_par"}, {24'h0, rec_data[DLEN + k]}, {24'h0, par[31 - 8*k -: 8]});
    for (int k = 0; k < NSYM; k++) begin
      ns += rec_sof[k];
      ne += rec_eof[k];
    end
    check_eq({tag, "_sof0"}, rec_sof[0], 1);
    check_eq({tag, "_eof31"}, rec_eof[NSYM-1], 1);
    check_eq({tag, "_nflags"}, {ns[15:0], ne[15:0]}, 32'h0001_0001);
  endtask

  task automatic check_idle(input string tag);
    check_eq(tag, {27'h0, o_valid, o_sof, o_eof, o_ready, |o_data}, 32'h2);
  endtask

  int rl;

  initial begin
    i_resb = 1'b0; i_frame_sync = 1'b0; i_valid = 1'b0; i_data = 8'h00; i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_resb = 1'b1;
    @(negedge i_clk);
    check_idle("reset_state");
    @(posedge i_clk); #1;

    // All-zero frame
    for (int k = 0; k < DLEN; k++) pay[k] = 8'h00;
    run_frame(1'b0, rl);
    check_frame("zero", 32'h00000000);
    check_eq("zero_ready_gap", rl, 4);

    // Single 1 in the last data position: parity equals g(x) coefficients
    pay[DLEN-1] = 8'h01;
    run_frame(1'b0, rl);
    check_frame("unit0", 32'h0F367840);
    check_eq("unit0_ready_gap", rl, 4);

    // Single 1 one position earlier, with random backpressure and stalls
    pay[DLEN-1] = 8'h00;
    pay[DLEN-2] = 8'h01;
    run_frame(1'b1, rl);
    check_frame("unit1", 32'h6357D2E7);

    // Random payload: codeword must have zero syndromes at 1, a, a^2, a^3
    for (int k = 0; k < DLEN; k++) pay[k] = 8'($urandom_range(0, 255));
    run_frame(1'b0, rl);
    for (int k = 0; k < DLEN; k++)
      check_eq("rand_data", {24'h0, rec_data[k]}, {24'h0, pay[k]});
    check_eq("rand_s0", {24'h0, syndrome(8'h01)}, 0);
    check_eq("rand_s1", {24'h0, syndrome(8'h02)}, 0);
    check_eq("rand_s2", {24'h0, syndrome(8'h04)}, 0);
    check_eq("rand_s3", {24'h0, syndrome(8'h08)}, 0);
    for (int k = 0; k < NSYM; k++) ref_data[k] = rec_data[k];

    // Same payload under backpressure must give the identical symbol stream
    run_frame(1'b1, rl);
    for (int k = 0; k < NSYM; k++)
      check_eq("bp_same", {24'h0, rec_data[k]}, {24'h0, ref_data[k]});

    // Abort a frame after 10 symbols, then encode a fresh unit frame
    for (int k = 0; k < DLEN; k++) pay[k] = 8'h5A;
    drive_n(10);
    i_frame_sync = 1'b1; i_valid = 1'b1; i_data = 8'hAA;
    @(negedge i_clk);
    check_eq("fsync_ready", o_ready, 0);
    @(posedge i_clk); #1;
    i_frame_sync = 1'b0; i_valid = 1'b0;
    @(negedge i_clk);
    check_idle("fsync_idle");
    @(posedge i_clk); #1;
    for (int k = 0; k < DLEN; k++) pay[k] = 8'h00;
    pay[DLEN-1] = 8'h01;
    run_frame(1'b0, rl);
    check_frame("fsync_new", 32'h0F367840);

    // Reset in the middle of parity output
    for (int k = 0; k < DLEN; k++) pay[k] = 8'hC3;
    drive_n(DLEN + 2);
    i_resb = 1'b0;
    @(posedge i_clk); #1;
    i_resb = 1'b1;
    @(negedge i_clk);
    check_idle("rst_mid_idle");
    @(posedge i_clk); #1;
    for (int k = 0; k < DLEN; k++) pay[k] = 8'h00;
    pay[DLEN-2] = 8'h01;
    run_frame(1'b0, rl);
    check_frame("rst_new", 32'h6357D2E7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
